// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and FSM encodings for the instruction-fetch stage
package fetch_pkg;

  localparam int          PC_STEP_DEF   = 4;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  // A request is on the bus in WAIT and DROP; DROP only waits out a stale response.
  function automatic logic req_state(input logic [1:0] s);
    return (s == S_WAIT) || (s == S_DROP);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/response bundle between fetch and imem
interface fetch_stage_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 32
);

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - pipeline register with flush > stall > load priority, async active-low reset
module ifid_reg #(
  parameter int                 PC_W      = 16,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               stall,
  input  logic               load,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [PC_W-1:0]    d_pc_plus,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc_plus
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_plus_q, pc_plus_d;

  always_comb begin
    valid_d   = valid_q;
    instr_d   = instr_q;
    pc_plus_d = pc_plus_q;
    if (flush) begin
      // pc_plus is left alone on a flush; only the bubble marker matters downstream
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (!stall) begin
      if (load) begin
        valid_d   = 1'b1;
        instr_d   = d_instr;
        pc_plus_d = d_pc_plus;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      instr_q   <= NOP_INSTR;
      pc_plus_q <= '0;
    end else begin
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pc_plus_q <= pc_plus_d;
    end
  end

  assign valid   = valid_q;
  assign instr   = instr_q;
  assign pc_plus = pc_plus_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: next-PC selection, single-outstanding imem fetch, IF/ID load
module fetch_stage #(
  parameter int                 PC_W      = 16,
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_STEP   = fetch_pkg::PC_STEP_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(fetch_pkg::NOP_INSTR_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc_cur,
  output logic [PC_W-1:0]    pc_next,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               id_stall,
  fetch_stage_if.master      imem,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc_plus
);

  import fetch_pkg::*;

  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

  logic [1:0]         state_q, state_d;
  logic [PC_W-1:0]    addr_q, addr_d;
  logic [INSTR_W-1:0] hold_q, hold_d;
  logic               in_wait, in_hold, deliver, issue;
  logic [INSTR_W-1:0] load_instr;

  always_comb begin
    in_wait = (state_q == S_WAIT);
    in_hold = (state_q == S_HOLD);
    deliver = !redirect && !id_stall && ((in_wait && imem.imem_ready) || in_hold);
    pc_next = redirect ? redirect_pc : (deliver ? pc_cur + STEP : pc_cur);
  end

  // Every issued address equals pc_next, which keeps imem_addr in step with the PC register.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: issue = 1'b1;
      S_WAIT: begin
        if (imem.imem_ready) begin
          if (redirect || !id_stall) begin
            issue = 1'b1;
          end else begin
            hold_d  = imem.imem_rdata;
            state_d = S_HOLD;
          end
        end else if (redirect) begin
          state_d = S_DROP;
        end
      end
      S_HOLD: issue = redirect || !id_stall;
      S_DROP: issue = imem.imem_ready;
      default: state_d = S_IDLE;
    endcase
    if (issue) begin
      addr_d  = pc_next;
      state_d = S_WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
    end
  end

  assign imem.imem_req  = req_state(state_q);
  assign imem.imem_addr = addr_q;
  assign load_instr     = in_hold ? hold_q : imem.imem_rdata;

  ifid_reg #(
    .PC_W      (PC_W),
    .INSTR_W   (INSTR_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .stall     (id_stall),
    .load      (deliver),
    .d_instr   (load_instr),
    .d_pc_plus (addr_q + STEP),
    .valid     (ifid_valid),
    .instr     (ifid_instr),
    .pc_plus   (ifid_pc_plus)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed vector table plus randomized run against a reference model
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pc_reg;
  logic [15:0] pc_next;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        id_stall = 1'b0;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [15:0] ifid_pc_plus;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_stage_if #(.PC_W(16), .INSTR_W(32)) imem ();

  fetch_stage #(.PC_W(16), .INSTR_W(32), .PC_STEP(4), .NOP_INSTR(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_cur       (pc_reg),
    .pc_next      (pc_next),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .id_stall     (id_stall),
    .imem         (imem),
    .ifid_valid   (ifid_valid),
    .ifid_instr   (ifid_instr),
    .ifid_pc_plus (ifid_pc_plus)
  );

  always @(posedge clk or negedge rst) begin
    if (!rst) pc_reg <= 16'h0;
    else      pc_reg <= pc_next;
  end

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a, ~a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rd, input logic [15:0] rpc,
                       input logic st, input logic rdy);
    rst = r;
    redirect = rd;
    redirect_pc = rpc;
    id_stall = st;
    imem.imem_ready = rdy;
    imem.imem_rdata = rdy ? mem_word(imem.imem_addr) : $urandom;
  endtask

  typedef struct {
    logic        rst;
    logic        redir;
    logic [15:0] rpc;
    logic        stall;
    logic        ready;
    logic [15:0] e_pcn;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_v;
    logic [15:0] e_pp;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rd, input logic [15:0] rpc,
                              input logic st, input logic rdy, input logic [15:0] pcn,
                              input logic rq, input logic [15:0] ad, input logic v,
                              input logic [15:0] pp);
    vec_t t;
    t.rst = r; t.redir = rd; t.rpc = rpc; t.stall = st; t.ready = rdy;
    t.e_pcn = pcn; t.e_req = rq; t.e_addr = ad; t.e_v = v; t.e_pp = pp;
    return t;
  endfunction

  vec_t tbl[$];

  logic        m_req, m_stale, m_buf_full, m_v;
  logic [15:0] m_addr, m_pp, m_pc;
  logic [31:0] m_buf, m_i;

  task automatic model_reset();
    m_req = 0; m_stale = 0; m_buf_full = 0; m_v = 0;
    m_addr = 0; m_pp = 0; m_pc = 0; m_buf = 0; m_i = 0;
  endtask

  initial begin
    logic [15:0] ppm4;
    logic        r, rd, st, rdy, dlv, new_req;
    logic [15:0] rpc, e_pcn;
    logic [31:0] rdata;

    imem.imem_ready = 1'b0;
    imem.imem_rdata = '0;

    //      rst rd rpc       st rdy  pc_next   req addr      v  pc_plus
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h0000, 1, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h0004, 1, 16'h0004, 1, 16'h0004));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h0008, 1, 16'h0008, 1, 16'h0008));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h000C, 1, 16'h000C, 1, 16'h000C));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h000C, 1, 16'h000C, 0, 16'h000C));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h0010, 1, 16'h0010, 1, 16'h0010));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 1, 16'h0010, 0, 16'h0010, 1, 16'h0010));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h0010, 0, 16'h0010, 1, 16'h0010));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 1, 16'h0010, 0, 16'h0010, 1, 16'h0010));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0014, 1, 16'h0014, 1, 16'h0014));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0014, 1, 16'h0014, 0, 16'h0014));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h0018, 1, 16'h0018, 1, 16'h0018));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h001C, 1, 16'h001C, 1, 16'h001C));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h0020, 1, 16'h0020, 1, 16'h0020));
    tbl.push_back(mk(1, 1, 16'h0200, 0, 0, 16'h0200, 1, 16'h0020, 0, 16'h0020));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0200, 1, 16'h0020, 0, 16'h0020));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h0200, 1, 16'h0200, 0, 16'h0020));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h0204, 1, 16'h0204, 1, 16'h0204));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 1, 16'h0204, 0, 16'h0204, 1, 16'h0204));
    tbl.push_back(mk(1, 1, 16'h0300, 1, 0, 16'h0300, 1, 16'h0300, 0, 16'h0204));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0300, 1, 16'h0300, 0, 16'h0204));
    tbl.push_back(mk(1, 1, 16'hFFFC, 0, 0, 16'hFFFC, 1, 16'h0300, 0, 16'h0204));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 1, 16'hFFFC, 1, 16'hFFFC, 0, 16'h0204));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h0000, 1, 16'h0000, 1, 16'h0000));

    // Bring the stage into WAIT so the first table row resets it mid-fetch.
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(1, 0, 16'h0, 0, 0);
    repeat (2) @(posedge clk);
    #1 chk("pre_reset_req", imem.imem_req, 1'b1);

    foreach (tbl[k]) begin
      @(negedge clk);
      drive(tbl[k].rst, tbl[k].redir, tbl[k].rpc, tbl[k].stall, tbl[k].ready);
      #1 chk($sformatf("v%0d_pc_next", k), pc_next, tbl[k].e_pcn);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_req", k), imem.imem_req, tbl[k].e_req);
      chk($sformatf("v%0d_addr", k), imem.imem_addr, tbl[k].e_addr);
      chk($sformatf("v%0d_valid", k), ifid_valid, tbl[k].e_v);
      chk($sformatf("v%0d_pc_plus", k), ifid_pc_plus, tbl[k].e_pp);
      ppm4 = 16'(tbl[k].e_pp - 16'd4);
      if (tbl[k].e_v)
        chk($sformatf("v%0d_instr", k), ifid_instr, mem_word(ppm4));
      else if (!tbl[k].rst)
        chk($sformatf("v%0d_reset_instr", k), ifid_instr, 32'h0);
    end

    @(negedge clk);
    drive(0, 0, 16'h0, 0, 0);
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      r   = ($urandom_range(99) != 0);
      rd  = ($urandom_range(9) == 0);
      rpc = 16'($urandom) & 16'hFFFC;
      st  = ($urandom_range(2) == 0);
      rdy = ($urandom_range(3) != 0);
      drive(r, rd, rpc, st, rdy);
      rdata = imem.imem_rdata;
      if (!r) model_reset();
      #1;
      dlv   = !rd && !st && ((m_req && !m_stale && rdy) || m_buf_full);
      e_pcn = rd ? rpc : (dlv ? 16'(m_pc + 16'd4) : m_pc);
      chk("rnd_pc_next", pc_next, e_pcn);
      chk("rnd_req", imem.imem_req, m_req);
      chk("rnd_addr", imem.imem_addr, m_addr);
      if (r) begin
        if (rd) begin
          m_v = 0; m_i = 32'h0;
        end else if (!st) begin
          if (dlv) begin
            m_v = 1; m_i = m_buf_full ? m_buf : rdata; m_pp = 16'(m_addr + 16'd4);
          end else begin
            m_v = 0;
          end
        end
        new_req = 0;
        if (m_buf_full) begin
          if (rd || !st) begin m_buf_full = 0; new_req = 1; end
        end else if (!m_req) begin
          new_req = 1;
        end else if (rdy) begin
          if (!m_stale && !rd && st) begin
            m_buf_full = 1; m_buf = rdata; m_req = 0;
          end else begin
            new_req = 1;
          end
        end else if (rd) begin
          m_stale = 1;
        end
        if (new_req) begin m_req = 1; m_addr = e_pcn; m_stale = 0; end
        m_pc = e_pcn;
      end
      @(posedge clk);
      #1;
      chk("rnd_valid", ifid_valid, m_v);
      chk("rnd_instr", ifid_instr, m_i);
      chk("rnd_pc_plus", ifid_pc_plus, m_pp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
